// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Registered 1-to-N stream demultiplexer with valid/ready flow control. Each
// input beat goes to one output channel, chosen either by s_sel (mode=0) or by
// an internal round-robin pointer (mode=1). A single output register gives one
// cycle of latency and still sustains one beat per cycle. Beats addressed to a
// channel that does not exist are consumed, dropped and counted.
//
// Parameters
//   DATA_W   payload width in bits (>= 1)
//   N_CH     number of output channels (2..16)
//   SEL_W    select width, N_CH <= 2**SEL_W
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = explicit select, 1 = round-robin (sampled per beat)
//   s_data     input payload
//   s_sel      destination channel, used only when mode=0
//   s_valid    input beat present
//   s_ready    block can accept a beat this cycle (independent of s_valid)
//   m_data     payload shared by all channels; changes only on a load
//   m_valid    one-hot per-channel valid
//   m_ready    per-channel ready; only the bit of the held channel matters
//   err_drop   one-cycle pulse per dropped beat
//   drop_cnt   saturating count of dropped beats
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [N_CH-1:0]   m_valid,
  input  logic [N_CH-1:0]   m_ready,
  output logic              err_drop,
  output logic [7:0]        drop_cnt
);

  // Channel count widened by one bit so a full-range select compares cleanly.
  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  logic              full;
  logic [SEL_W-1:0]  ch_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  rr_ptr;

  logic [N_CH-1:0]   ch_onehot;
  logic              head_ready;
  logic              accept;
  logic [SEL_W-1:0]  dst;
  logic              dst_ok;
  logic              load;
  logic              drop;

  // ch_q is only ever loaded with a valid channel, so the shift never falls
  // off the top of the vector.
  assign ch_onehot  = N_CH'(1) << ch_q;
  assign head_ready = |(m_ready & ch_onehot);

  // Ready whenever the register is empty or its beat leaves this cycle;
  // forced low while in reset so nothing is taken during reset.
  assign s_ready = rst_n & (~full | head_ready);
  assign accept  = s_valid & s_ready;

  assign dst    = mode ? rr_ptr : s_sel;
  assign dst_ok = ({1'b0, dst} < N_CH_EXT);
  assign load   = accept & dst_ok;
  assign drop   = accept & ~dst_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      ch_q     <= '0;
      data_q   <= '0;
      rr_ptr   <= '0;
      drop_cnt <= 8'd0;
      err_drop <= 1'b0;
    end else begin
      // A load wins over a consume: the new beat replaces the departing one
      // with no bubble. A dropped beat behaves like no beat for the register.
      if (load) begin
        full   <= 1'b1;
        ch_q   <= dst;
        data_q <= s_data;
      end else if (full && head_ready) begin
        full <= 1'b0;
      end

      err_drop <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      // Pointer holds in explicit mode so round-robin resumes where it left off.
      if (accept && mode) begin
        rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

  assign m_valid = full ? ch_onehot : '0;
  assign m_data  = data_q;

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready flow control. It routes each input beat to one of `N_CH` output channels, selected either per beat by `s_sel` or by an internal round-robin pointer. A single output register gives one cycle of latency and full throughput. Beats addressed to a non-existent channel are dropped and counted. It replaces the combinational 4-way demux wherever the destination can apply backpressure.

## Interface
- `DATA_W`, 8, payload width in bits (≥1)
- `N_CH`, 4, number of output channels (2..16)
- `SEL_W`, 2, select width; must satisfy `N_CH <= 2**SEL_W`
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst_n`  input  1  reset, asynchronous and active-low
- `mode`  input  1  0 = explicit select, 1 = round-robin
- `s_data`  input  DATA_W  input payload
- `s_sel`  input  SEL_W  destination channel; used only when `mode`=0
- `s_valid`  input  1  input beat present
- `s_ready`  output  1  block can accept a beat this cycle
- `m_data`  output  DATA_W  payload, shared by all channels
- `m_valid`  output  N_CH  one-hot; bit k set means the beat is for channel k
- `m_ready`  input  N_CH  per-channel ready
- `err_drop`  output  1  one-cycle pulse for each dropped beat
- `drop_cnt`  output  8  saturating count of dropped beats

## Operation
- State:
  - output register (`full`, `ch_q`, `data_q`)
  - round-robin pointer `rr_ptr` (SEL_W bits)
  - `drop_cnt`
  - `err_drop` flop
- `s_ready` = `rst_n` && (!`full` || `m_ready[ch_q]`). It is combinational, but does not depend on `s_valid`.
- Accept = `s_valid` && `s_ready`.
- Destination `dst` is `s_sel` when `mode`=0 and `rr_ptr` when `mode`=1.
- Accept with `dst < N_CH`:
  - load `data_q`←`s_data`, `ch_q`←`dst`, `full`←1.
- Accept with `dst >= N_CH` (possible only in mode 0):
  - the beat is consumed and discarded.
  - `err_drop`←1 for one cycle; `drop_cnt` increments, saturating at 255.
  - the output register updates as if no beat arrived (it empties if its beat was taken, else holds).
- Output handshake: when `full` && `m_ready[ch_q]` && no valid accept in the same cycle, `full`←0.
  - Ready on any channel other than `ch_q` is ignored.
- `m_valid` = `full` ? one-hot(`ch_q`) : 0.
- `m_data` = `data_q`. It holds its last value when not valid and changes only on a load.
- Round-robin pointer:
  - advances only on an accept while `mode`=1.
  - `rr_ptr`←(`rr_ptr`==N_CH-1) ? 0 : `rr_ptr`+1.
  - holds while `mode`=0, so resuming mode 1 continues from where it left off.
- `mode` is sampled per beat at accept time. Switching mode mid-stream is legal and never corrupts the beat held in the output register.
- Reset mid-operation: any held beat is lost and no `err_drop` is produced. Upstream must re-send.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `full`=0, `m_valid`=0, `m_data`=0, `ch_q`=0
  - `rr_ptr`=0, `drop_cnt`=0, `err_drop`=0
  - `s_ready`=0 while `rst_n` is low
- First accept is possible in the first rising edge after `rst_n` deasserts.
- Latency: a beat accepted at edge t appears on `m_valid`/`m_data` after edge t; earliest consumption is edge t+1.
- Throughput: one beat per cycle with continuous `m_ready[ch_q]`, including back-to-back beats to different channels.
- Simultaneous consume and accept in one cycle: the new beat replaces the old one with no bubble.
- Backpressure: while `full` and !`m_ready[ch_q]`, `s_ready`=0 and `m_valid`, `m_data`, `ch_q` are stable.
- `err_drop` asserts in the cycle after the dropping edge, for exactly one cycle per dropped beat. Consecutive drops keep it high.

## Test plan
- Reset and explicit select (`N_CH`=4, `mode`=0, all `m_ready`=1):
  - stimulus: beats 0xA1/sel0, 0xA2/sel1, 0xA3/sel2, 0xA4/sel3 on consecutive cycles.
  - required: `m_valid` = 0001, 0010, 0100, 1000 on consecutive cycles, with matching data and 1-cycle latency; `s_ready` stays 1.
- Backpressure:
  - stimulus: beat 0x55 to ch2 with `m_ready`=0000 for 3 cycles, then 0100; a second beat 0x66 is held pending.
  - required: `s_ready`=0 and `m_valid`=0100/0x55 stable for 3 cycles; 0x66 is accepted in the same cycle 0x55 is consumed.
  - required: ready on ch0 alone never releases the ch2 beat.
- Round-robin (`mode`=1):
  - stimulus: 6 beats 0x10..0x15 with `s_sel` held at 3.
  - required: routed to channels 0, 1, 2, 3, 0, 1.
  - stimulus: switch to `mode`=0 for one beat to ch3, then back to `mode`=1.
  - required: the next beat goes to ch2.
- Invalid select (`N_CH`=3, `SEL_W`=2):
  - stimulus: beat with sel 3.
  - required: accepted, `m_valid` stays 0, `err_drop` pulses 1 cycle, `drop_cnt`=1.
  - stimulus: 300 such beats.
  - required: `drop_cnt`=255.
- Reset mid-operation:
  - stimulus: beat held at ch1 with `m_ready`=0, then `rst_n` pulsed low.
  - required: `m_valid`=0 immediately; `rr_ptr`, `drop_cnt` cleared; no `err_drop`; normal accept after release.
- Random soak (`DATA_W`=16, `N_CH`=5):
  - stimulus: random valid/ready/sel/mode for 10k cycles.
  - required: the scoreboard sees every valid beat exactly once, in order, on the correct channel; drops equal the count of sel ≥5 accepts.
